// File: rtl/frs_sequencer.sv
// Four-lane collector for the Daub-6 final reconstruction stage: gathers one sample per lane,
// then emits the floor-average (l0+l1+l2+l3)>>>2 through a registered valid/ready output.
module frs_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic [3:0]              lane_valid,
  input  logic [4*DATA_WIDTH-1:0] lane_data,
  output logic [3:0]              lane_ready,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  input  logic                    out_ready,
  output logic [CNT_WIDTH-1:0]    set_count,
  output logic                    busy
);

  logic [3:0]                   full;
  logic signed [DATA_WIDTH-1:0] slot [4];
  logic signed [DATA_WIDTH+1:0] sum;
  logic [3:0]                   capture;
  logic                         fire;

  assign lane_ready = ~full;
  assign capture    = lane_valid & ~full;
  assign fire       = (&full) & (~out_valid | out_ready);
  assign busy       = (|full) | out_valid;

  // Two guard bits make the 4-way sum exact; size cast sign-extends each slot.
  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      sum = sum + (DATA_WIDTH+2)'(slot[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      set_count <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        slot[i] <= '0;
      end
    end else if (clr) begin
      full      <= '0;
      out_valid <= 1'b0;
      set_count <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (capture[i]) begin
          full[i] <= 1'b1;
          slot[i] <= lane_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      // fire only happens with every slot full, so it never collides with a capture
      if (fire) begin
        full      <= '0;
        out_data  <= DATA_WIDTH'(sum >>> 2);
        out_valid <= 1'b1;
        set_count <= set_count + CNT_WIDTH'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frs_sequencer.sv
// Directed bench for frs_sequencer: stimulus pushes expected samples into a queue,
// an independent monitor pops and compares on every output transfer.
module tb_frs_sequencer;

  localparam int DW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic [3:0]    lane_valid = '0;
  logic [4*DW-1:0] lane_data = '0;
  logic [3:0]    lane_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic [CW-1:0] set_count;
  logic          busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  longint expq[$];
  bit stream_chk = 0;
  int stream_n = 0;
  int last_cyc = 0;

  frs_sequencer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .lane_valid(lane_valid), .lane_data(lane_data), .lane_ready(lane_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .set_count(set_count), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: a transfer is committed at the next rising edge when valid & ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious output: got %0d expected none", $signed(out_data));
      end else begin
        chk("out_data", $signed(out_data), expq.pop_front());
      end
      if (stream_chk) begin
        if (stream_n > 0) chk("stream gap", cyc - last_cyc, 2);
        chk("stream set_count", set_count, (stream_n + 1) % 16);
        last_cyc = cyc;
        stream_n++;
      end
    end
  end

  task automatic send(input logic [3:0] m, input int d0, input int d1, input int d2, input int d3);
    logic [3:0] acc;
    lane_data  = {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
    lane_valid = m;
    for (int k = 0; k < 100 && lane_valid != 0; k++) begin
      @(negedge clk);
      acc = lane_valid & lane_ready;
      @(posedge clk);
      #1 lane_valid = lane_valid & ~acc;
    end
    if (lane_valid != 0) begin
      chk("lane accept timeout", lane_valid, 0);
      lane_valid = '0;
    end
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 200 && (expq.size() != 0 || out_valid); k++) @(posedge clk);
    #1;
    if (k == 200) chk("drain timeout", expq.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    expq.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();
    chk("reset lane_ready", lane_ready, 4'b1111);
    chk("reset busy", busy, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset set_count", set_count, 0);

    // All lanes in one cycle, latency check
    out_ready = 1'b1;
    expq.push_back(250);
    lane_data  = {16'sd400, 16'sd300, 16'sd200, 16'sd100};
    lane_valid = 4'b1111;
    @(posedge clk);
    #1 lane_valid = '0;
    chk("latency out_valid N", out_valid, 0);
    chk("latency lane_ready N", lane_ready, 4'b0000);
    chk("latency busy N", busy, 1);
    @(posedge clk);
    #1;
    chk("latency out_valid N+1", out_valid, 1);
    chk("latency out_data N+1", $signed(out_data), 250);
    chk("set_count after 1", set_count, 1);
    chk("lane_ready reopened", lane_ready, 4'b1111);
    drain();

    // Separate arrivals, order 3,0,2,1
    expq.push_back(-2);
    send(4'b1000, -1, -1, -1, -2);
    send(4'b0001, -1, -1, -1, -2);
    send(4'b0100, 777, -1, -1, 777);
    send(4'b0010, 555, -1, 555, 555);
    drain();

    // Extremes
    expq.push_back(32767);
    send(4'b1111, 32767, 32767, 32767, 32767);
    expq.push_back(-32768);
    send(4'b1111, -32768, -32768, -32768, -32768);
    expq.push_back(-1);
    send(4'b1111, 32767, 32767, -32768, -32768);
    drain();
    chk("set_count after 5", set_count, 5);

    // Backpressure with a second set queued
    out_ready = 1'b0;
    expq.push_back(2);
    send(4'b1111, 1, 2, 3, 4);
    expq.push_back(40);
    send(4'b1111, 40, 40, 40, 40);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold out_valid", out_valid, 1);
      chk("hold out_data", $signed(out_data), 2);
      chk("hold lane_ready", lane_ready, 4'b0000);
    end
    out_ready = 1'b1;
    drain();
    chk("backpressure both delivered", expq.size(), 0);

    // Async reset mid-operation
    out_ready = 1'b0;
    expq.push_back(10);
    send(4'b1111, 10, 10, 10, 10);
    @(posedge clk);
    #1;
    send(4'b0011, 5, 6, 7, 8);
    chk("pre-reset out_valid", out_valid, 1);
    #1 rst_n = 1'b0;
    expq.delete();
    #1;
    chk("midreset out_valid", out_valid, 0);
    chk("midreset out_data", out_data, 0);
    chk("midreset lane_ready", lane_ready, 4'b1111);
    chk("midreset busy", busy, 0);
    chk("midreset set_count", set_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("no replay after reset", out_valid, 0);

    // clr with three slots full
    expq.push_back(8);
    send(4'b1111, 8, 8, 8, 8);
    drain();
    send(4'b0111, 5, 5, 5, 5);
    chk("pre-clr busy", busy, 1);
    chk("pre-clr set_count", set_count, 1);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    chk("clr busy", busy, 0);
    chk("clr set_count", set_count, 0);
    chk("clr lane_ready", lane_ready, 4'b1111);
    expq.push_back(26);
    send(4'b1111, 20, 24, 28, 32);
    drain();
    chk("post-clr set_count", set_count, 1);

    // Streaming 17 sets: throughput and 4-bit counter wrap
    do_reset();
    out_ready = 1'b1;
    stream_n = 0;
    stream_chk = 1;
    for (int k = 1; k <= 17; k++) begin
      expq.push_back(4 * k);
      send(4'b1111, 4 * k, 4 * k, 4 * k, 4 * k);
    end
    drain();
    stream_chk = 0;
    chk("stream outputs", stream_n, 17);
    chk("wrapped set_count", set_count, 1);

    chk("queue empty", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
